// File: rtl/rat_pkg.sv
// Shared RAT CPU datapath types: program-counter address width and address type.
// Used by the program counter and the return-address stack so both agree on the width.
package rat_pkg;
  localparam int ADDR_W = 10;
  typedef logic [ADDR_W-1:0] pc_addr_t;
endpackage

// File: rtl/return_stack.sv
// Return-address stack: push on CALL, pop on RET. All updates on the RS_CLK rising edge;
// top/flags are combinational from registers. No backpressure: errors are sticky flags, never stalls.
module return_stack
  import rat_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int STK_ADDRW = rat_pkg::ADDR_W
) (
  input  logic                       RS_CLK,
  input  logic                       RS_RST_N,
  input  logic                       RS_PUSH,
  input  logic                       RS_POP,
  input  logic                       RS_FLUSH,
  input  logic                       RS_CLR_ERR,
  input  logic [STK_ADDRW-1:0]       RS_DIN,
  output logic [STK_ADDRW-1:0]       RS_TOP,
  output logic                       RS_EMPTY,
  output logic                       RS_FULL,
  output logic [$clog2(DEPTH):0]     RS_COUNT,
  output logic                       RS_OVF,
  output logic                       RS_UNF
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [STK_ADDRW-1:0] r_mem [DEPTH];
  logic [CW-1:0]        r_count;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_empty;
  logic                 w_full;
  logic [CW-1:0]        w_top_cnt;
  logic [PW-1:0]        w_top_idx;
  logic [PW-1:0]        w_wr_idx;
  logic                 w_ovf_evt;
  logic                 w_unf_evt;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_top_cnt = r_count - CW'(1);
  assign w_top_idx = w_top_cnt[PW-1:0];
  assign w_wr_idx  = r_count[PW-1:0];

  // Flush suppresses push/pop entirely, so it also suppresses their error events.
  assign w_ovf_evt = !RS_FLUSH && RS_PUSH && !RS_POP && w_full;
  assign w_unf_evt = !RS_FLUSH && RS_POP && !RS_PUSH && w_empty;

  always_ff @(posedge RS_CLK or negedge RS_RST_N) begin
    if (!RS_RST_N) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (RS_FLUSH) begin
      r_count <= '0;
    end else if (RS_PUSH && RS_POP && !w_empty) begin
      r_mem[w_top_idx] <= RS_DIN;
    end else if (RS_PUSH) begin
      if (!w_full) begin
        r_mem[w_wr_idx] <= RS_DIN;
        r_count         <= r_count + CW'(1);
      end
    end else if (RS_POP && !w_empty) begin
      r_count <= w_top_cnt;
    end
  end

  always_ff @(posedge RS_CLK or negedge RS_RST_N) begin
    if (!RS_RST_N) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~RS_CLR_ERR);
      r_unf <= w_unf_evt | (r_unf & ~RS_CLR_ERR);
    end
  end

  assign RS_TOP   = w_empty ? '0 : r_mem[w_top_idx];
  assign RS_EMPTY = w_empty;
  assign RS_FULL  = w_full;
  assign RS_COUNT = r_count;
  assign RS_OVF   = r_ovf;
  assign RS_UNF   = r_unf;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: LIFO order, saturation, sticky errors, replace-top, flush, async reset.
module tb_return_stack;

  logic       clk;
  logic       rst_n;
  logic       push, pop, flush, clr_err;
  logic [9:0] din;
  logic [9:0] top;
  logic       empty, full, ovf, unf;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  return_stack #(.DEPTH(8), .STK_ADDRW(10)) dut (
    .RS_CLK(clk), .RS_RST_N(rst_n), .RS_PUSH(push), .RS_POP(pop),
    .RS_FLUSH(flush), .RS_CLR_ERR(clr_err), .RS_DIN(din), .RS_TOP(top),
    .RS_EMPTY(empty), .RS_FULL(full), .RS_COUNT(count), .RS_OVF(ovf), .RS_UNF(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of strobes across a rising edge; returns #1 after that edge.
  task automatic cyc(input logic p_push, input logic p_pop, input logic [9:0] p_din,
                     input logic p_flush, input logic p_clr);
    push = p_push; pop = p_pop; din = p_din; flush = p_flush; clr_err = p_clr;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; din = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push = 0; pop = 0; flush = 0; clr_err = 0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (top !== 10'h000) begin n_fail++; $display("FAIL reset_top got %h want 000", top); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got ovf=%b unf=%b want 0 0", ovf, unf); end
  endtask

  task automatic test_lifo();
    logic [9:0] exp_seq [3];
    exp_seq[0] = 10'h3FF; exp_seq[1] = 10'h345; exp_seq[2] = 10'h012;
    cyc(1, 0, 10'h012, 0, 0);
    cyc(1, 0, 10'h345, 0, 0);
    cyc(1, 0, 10'h3FF, 0, 0);
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL lifo_count got %0d want 3", count); end
    n_checks++; if (top !== 10'h3FF) begin n_fail++; $display("FAIL lifo_top got %h want 3ff", top); end
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      #1;
      n_checks++; if (top !== exp_seq[i]) begin n_fail++; $display("FAIL lifo_pop%0d got %h want %h", i, top, exp_seq[i]); end
      @(posedge clk); #1;
      pop = 1'b0;
    end
    n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL lifo_end got empty=%b count=%0d want 1 0", empty, count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) cyc(1, 0, 10'h100 + 10'(i), 0, 0);
    n_checks++; if (full !== 1'b1 || count !== 4'd8) begin n_fail++; $display("FAIL ovf_fill got full=%b count=%0d want 1 8", full, count); end
    n_checks++; if (top !== 10'h107) begin n_fail++; $display("FAIL ovf_fill_top got %h want 107", top); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", ovf); end
    cyc(1, 0, 10'h200, 0, 0);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf); end
    n_checks++; if (top !== 10'h107 || count !== 4'd8) begin n_fail++; $display("FAIL ovf_preserve got top=%h count=%0d want 107 8", top, count); end
    cyc(0, 1, 10'h000, 0, 0);
    n_checks++; if (top !== 10'h106 || count !== 4'd7) begin n_fail++; $display("FAIL ovf_pop got top=%h count=%0d want 106 7", top, count); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    cyc(0, 0, 10'h000, 0, 1);
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", ovf); end
    cyc(0, 0, 10'h000, 1, 0);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_flush got empty=%b want 1", empty); end
  endtask

  task automatic test_underflow();
    cyc(0, 1, 10'h000, 0, 0);
    n_checks++; if (unf !== 1'b1) begin n_fail++; $display("FAIL unf_set got %b want 1", unf); end
    n_checks++; if (count !== 4'd0 || top !== 10'h000) begin n_fail++; $display("FAIL unf_state got count=%0d top=%h want 0 000", count, top); end
    cyc(0, 0, 10'h000, 0, 1);
    n_checks++; if (unf !== 1'b0) begin n_fail++; $display("FAIL unf_clr got %b want 0", unf); end
    cyc(1, 1, 10'h055, 0, 0);
    n_checks++; if (count !== 4'd1 || top !== 10'h055) begin n_fail++; $display("FAIL pushpop_empty got count=%0d top=%h want 1 055", count, top); end
    n_checks++; if (unf !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty_unf got %b want 0", unf); end
    cyc(0, 0, 10'h000, 1, 0);
    // Error event and clear in the same cycle: the event wins.
    cyc(0, 1, 10'h000, 0, 1);
    n_checks++; if (unf !== 1'b1) begin n_fail++; $display("FAIL unf_clr_collide got %b want 1", unf); end
    cyc(0, 0, 10'h000, 0, 1);
  endtask

  task automatic test_replace_flush();
    cyc(1, 0, 10'h090, 0, 0);
    cyc(1, 0, 10'h0A0, 0, 0);
    n_checks++; if (count !== 4'd2 || top !== 10'h0A0) begin n_fail++; $display("FAIL repl_setup got count=%0d top=%h want 2 0a0", count, top); end
    cyc(1, 1, 10'h0B0, 0, 0);
    n_checks++; if (count !== 4'd2 || top !== 10'h0B0) begin n_fail++; $display("FAIL repl_top got count=%0d top=%h want 2 0b0", count, top); end
    n_checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_fail++; $display("FAIL repl_flags got ovf=%b unf=%b want 0 0", ovf, unf); end
    cyc(0, 1, 10'h000, 0, 0);
    n_checks++; if (top !== 10'h090 || count !== 4'd1) begin n_fail++; $display("FAIL repl_below got top=%h count=%0d want 090 1", top, count); end
    cyc(1, 0, 10'h0C0, 0, 0);
    cyc(1, 0, 10'h1C1, 1, 0);
    n_checks++; if (count !== 4'd0 || empty !== 1'b1 || top !== 10'h000) begin n_fail++; $display("FAIL flush_push got count=%0d empty=%b top=%h want 0 1 000", count, empty, top); end
    // Flush while empty with pop high must not raise underflow.
    cyc(0, 1, 10'h000, 1, 0);
    n_checks++; if (unf !== 1'b0) begin n_fail++; $display("FAIL flush_pop_unf got %b want 0", unf); end
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 10'h011, 0, 0);
    cyc(1, 0, 10'h022, 0, 0);
    cyc(1, 0, 10'h033, 0, 0);
    cyc(0, 1, 10'h000, 0, 0);
    cyc(0, 1, 10'h000, 0, 0);
    cyc(0, 1, 10'h000, 0, 0);
    cyc(0, 1, 10'h000, 0, 0);
    cyc(1, 0, 10'h044, 0, 0);
    cyc(1, 0, 10'h055, 0, 0);
    cyc(1, 0, 10'h066, 0, 0);
    n_checks++; if (count !== 4'd3 || unf !== 1'b1) begin n_fail++; $display("FAIL arst_setup got count=%0d unf=%b want 3 1", count, unf); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0 || empty !== 1'b1 || top !== 10'h000) begin n_fail++; $display("FAIL arst_state got count=%0d empty=%b top=%h want 0 1 000", count, empty, top); end
    n_checks++; if (unf !== 1'b0 || ovf !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL arst_flags got unf=%b ovf=%b full=%b want 0 0 0", unf, ovf, full); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_release got empty=%b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
